// File: rtl/load_seq_unit.sv
// LSU load unit: one- or two-beat reads with byte merge and sign/zero extension.
// Define LOAD_SEQ_SPLIT_EN to split bus-word-crossing loads instead of faulting.
module load_seq_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN/8-1:0] mem_rstrb_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   resp_data_o,
  output logic [TAG_W-1:0]  resp_tag_o,
  output logic              resp_misaligned_o
);
  localparam int B  = XLEN / 8;
  localparam int OW = $clog2(B);

  typedef enum logic [2:0] {
    IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [TAG_W-1:0]  tag_q;
  logic              fault_q;
  logic [XLEN-1:0]   data_q;
  logic              accept, done;

  logic [OW-1:0]     in_off;
  logic [3:0]        in_n;
  logic              in_cross, in_bad, in_fault;

  assign in_off   = req_addr_i[OW-1:0];
  assign in_n     = 4'd1 << req_size_i;
  assign in_cross = (5'(in_off) + 5'(in_n)) > 5'(B);
  assign in_bad   = (XLEN == 32) && (req_size_i == 2'd3);
`ifdef LOAD_SEQ_SPLIT_EN
  assign in_fault = in_bad;
`else
  assign in_fault = in_bad | in_cross;
`endif

  logic [OW-1:0]     off_q;
  logic [3:0]        n_q;
  logic [B-1:0]      nm, strb0;
  logic [ADDR_W-1:0] base;
  logic [2*XLEN-1:0] pair;

  assign off_q = addr_q[OW-1:0];
  assign n_q   = 4'd1 << size_q;
  assign nm    = (n_q >= 4'(B)) ? '1 : ~({B{1'b1}} << n_q);
  assign strb0 = nm << off_q;
  assign base  = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};

`ifdef LOAD_SEQ_SPLIT_EN
  logic              cross_q, load0;
  logic [XLEN-1:0]   beat0_q;
  logic [B-1:0]      strb1;
  // Second beat covers the bytes that spilled past the first word.
  assign strb1 = nm >> (4'(B) - 4'(off_q));
  assign pair  = (state_q == WAIT1) ? {mem_rdata_i, beat0_q}
                                    : {{XLEN{1'b0}}, mem_rdata_i};
`else
  assign pair  = {{XLEN{1'b0}}, mem_rdata_i};
`endif

  function automatic logic [XLEN-1:0] fmt(
    input logic [2*XLEN-1:0] p,
    input logic [OW-1:0]     off,
    input logic [1:0]        sz,
    input logic              un
  );
    logic [2*XLEN-1:0] sh;
    logic [XLEN-1:0]   lo, msk, msb;
    logic [6:0]        nb;
    logic              sgn;
    sh  = p >> {off, 3'b000};
    lo  = sh[XLEN-1:0];
    nb  = 7'd8 << sz;
    msk = (nb >= 7'(XLEN)) ? '1 : ~({XLEN{1'b1}} << nb);
    msb = msk & ~(msk >> 1);
    sgn = |(lo & msb);
    return un ? (lo & msk) : ((lo & msk) | (sgn ? ~msk : '0));
  endfunction

  always_comb begin
    state_d           = state_q;
    accept            = 1'b0;
    done              = 1'b0;
    req_ready_o       = 1'b0;
    mem_req_valid_o   = 1'b0;
    mem_addr_o        = '0;
    mem_rstrb_o       = '0;
    resp_valid_o      = 1'b0;
    resp_data_o       = '0;
    resp_tag_o        = '0;
    resp_misaligned_o = 1'b0;
`ifdef LOAD_SEQ_SPLIT_EN
    load0             = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = in_fault ? RESP : REQ0;
        end
      end
      REQ0: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = base;
        mem_rstrb_o     = strb0;
        if (mem_req_ready_i) state_d = WAIT0;
      end
      WAIT0: begin
        if (mem_rvalid_i) begin
`ifdef LOAD_SEQ_SPLIT_EN
          if (cross_q) begin
            load0   = 1'b1;
            state_d = REQ1;
          end else begin
            done    = 1'b1;
            state_d = RESP;
          end
`else
          done    = 1'b1;
          state_d = RESP;
`endif
        end
      end
`ifdef LOAD_SEQ_SPLIT_EN
      REQ1: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = base + ADDR_W'(B);
        mem_rstrb_o     = strb1;
        if (mem_req_ready_i) state_d = WAIT1;
      end
      WAIT1: begin
        if (mem_rvalid_i) begin
          done    = 1'b1;
          state_d = RESP;
        end
      end
`endif
      RESP: begin
        resp_valid_o      = 1'b1;
        resp_data_o       = data_q;
        resp_tag_o        = tag_q;
        resp_misaligned_o = fault_q;
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      tag_q   <= '0;
      fault_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr_i;
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        tag_q   <= req_tag_i;
        fault_q <= in_fault;
        data_q  <= '0;
      end
      if (done) data_q <= fmt(pair, off_q, size_q, uns_q);
    end
  end

`ifdef LOAD_SEQ_SPLIT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cross_q <= 1'b0;
      beat0_q <= '0;
    end else begin
      if (accept) cross_q <= in_cross;
      if (load0)  beat0_q <= mem_rdata_i;
    end
  end
`endif

endmodule
